// File: rtl/accel_mem_pkg.sv
// ---------------------------------------------------------------------------
// accel_mem_pkg
// Shared types and constants for the accelerator data-memory streamers
// (burst reader today, write-side streamer later).
//   state_t    : burst FSM states shared by the streamers
//   addr_t     : word address for the default 256-word memory
//   len_t      : burst length 0..MEM_DEPTH (one bit wider than addr_t)
//   SKID_DEPTH : entries in the read-latency skid buffer
// ---------------------------------------------------------------------------
package accel_mem_pkg;

  localparam int MEM_DEPTH  = 256;
  localparam int MEM_AW     = $clog2(MEM_DEPTH);
  localparam int SKID_DEPTH = 2;

  typedef logic [MEM_AW-1:0] addr_t;
  typedef logic [MEM_AW:0]   len_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/skid_fifo2.sv
// ---------------------------------------------------------------------------
// skid_fifo2
// Two-entry valid/ready buffer with registered outputs. The producer is
// expected to respect count (it has no ready of its own), which lets a
// memory-read initiator decide ahead of time whether a word it is about to
// request will have a slot when it comes back.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid, in_data     : push side (push happens whenever in_valid=1)
//   out_valid, out_data   : head of the buffer, registered
//   out_ready             : consumer accepts the head this cycle
//   count                 : number of occupied entries, 0..2
// ---------------------------------------------------------------------------
module skid_fifo2
  import accel_mem_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  assign push      = in_valid && (int'(count_q) < SKID_DEPTH || out_ready);
  assign pop       = out_ready && (count_q != 2'd0);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign count     = count_q;

  // The head register always holds the oldest word so the output is a plain
  // flop; the tail only fills when the head is already occupied and not
  // leaving this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= in_data;
          else                 tail_q <= in_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= in_data;
          end else begin
            head_q <= tail_q;
            tail_q <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_burst_reader.sv
// ---------------------------------------------------------------------------
// mem_burst_reader
// Read-side initiator for the single-port synchronous-read data memory.
// Fetches `len` consecutive words starting at `base_addr` (wrapping modulo
// DEPTH) and streams them to the PE array over valid/ready. The RAM's
// one-cycle read latency is absorbed by a 2-entry skid buffer so the stream
// runs at one word per cycle when the consumer never stalls.
//
// Optional feature: define MEM_BURST_READER_STRIDE_EN to add a `stride`
// input (captured at start); addresses then advance by stride mod DEPTH
// instead of by 1.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : burst request, honoured only in IDLE
//   base_addr, len       : first word address and word count (0..DEPTH)
//   stride               : address step (only with MEM_BURST_READER_STRIDE_EN)
//   busy                 : burst in progress (cycle after start until done)
//   done                 : one-cycle completion pulse
//   mem_we, mem_addr     : memory control (write enable tied low)
//   mem_rdata            : memory read data, one cycle after mem_addr
//   m_valid, m_ready     : output stream handshake
//   m_data, m_last       : output word and end-of-burst marker
// ---------------------------------------------------------------------------
module mem_burst_reader
  import accel_mem_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = MEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
`ifdef MEM_BURST_READER_STRIDE_EN
  input  logic [AW-1:0]    stride,
`endif
  input  logic [AW:0]      len,
  output logic             busy,
  output logic             done,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  state_t          state_q;
  logic [AW-1:0]   addr_q;
  logic [AW:0]     issue_left_q;
  logic            inflight_q;
  logic            inflight_last_q;
  logic            busy_q;
  logic            done_q;
  logic [AW-1:0]   step;

  logic            pop;
  logic            issue;
  logic            last_issue;
  logic [2:0]      occ;
  logic [1:0]      buf_count;
  logic [WIDTH:0]  buf_out;

`ifdef MEM_BURST_READER_STRIDE_EN
  logic [AW-1:0]   stride_q;
  assign step = stride_q;
`else
  assign step = AW'(1);
`endif

  // A read may only be issued if its word is guaranteed a buffer slot when
  // it returns next cycle: words already buffered plus the one still in
  // flight, minus the one leaving now, must leave room.
  assign pop        = m_valid && m_ready;
  assign occ        = {1'b0, buf_count} + {2'b00, inflight_q};
  assign issue      = (state_q == RUN) && (issue_left_q != '0) &&
                      (occ < 3'(SKID_DEPTH) + {2'b00, pop});
  assign last_issue = issue && (issue_left_q == (AW+1)'(1));

  assign mem_we   = 1'b0;
  assign mem_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign m_data   = buf_out[WIDTH-1:0];
  assign m_last   = buf_out[WIDTH];

  // Burst FSM: captures the request, walks the address, and tags each read
  // with whether it is the final word so m_last travels with its data
  // through the skid buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      issue_left_q    <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
`ifdef MEM_BURST_READER_STRIDE_EN
      stride_q        <= '0;
`endif
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            addr_q       <= base_addr;
            issue_left_q <= len;
`ifdef MEM_BURST_READER_STRIDE_EN
            stride_q     <= stride;
`endif
            if (len == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr_q       <= addr_q + step;
            issue_left_q <= issue_left_q - (AW+1)'(1);
          end
          if (pop && m_last) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (last_issue) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  skid_fifo2 #(
    .WIDTH(WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (inflight_q),
    .in_data  ({inflight_last_q, mem_rdata}),
    .out_valid(m_valid),
    .out_data (buf_out),
    .out_ready(m_ready),
    .count    (buf_count)
  );

endmodule

// File: tb/tb_mem_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_reader
// Directed bench for mem_burst_reader: a table of bursts with hand-computed
// expected beats, plus hand-written reset and mid-burst reset sequences.
// The memory model holds mem[i]=i with a one-cycle synchronous read.
// ---------------------------------------------------------------------------
module tb_mem_burst_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [AW:0]      len = '0;
  logic             busy;
  logic             done;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_rdata = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             we_seen = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    logic [15:0] ready;
    int          mid_start;
    int          abort_beats;
    int          exp_done;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [7];
  vec_t abort_vec;
  vec_t after_vec;

  mem_burst_reader #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
`ifdef MEM_BURST_READER_STRIDE_EN
    .stride   (8'd1),
`endif
    .len      (len),
    .busy     (busy),
    .done     (done),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model plus a watch on the write enable.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we !== 1'b0) we_seen <= 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Runs one burst from the table: pulses start, drives m_ready from the
  // 16-bit pattern (bit = cycle mod 16), and checks every beat, hold during
  // stalls, latency and the done pulse. Cycle 0 is the start cycle.
  task automatic applyStimulus(input vec_t v, input string tag);
    int         beats;
    int         first_valid;
    int         done_cycle;
    logic       prev_stall;
    logic       prev_last;
    logic [7:0] prev_data;
    logic [7:0] exp_byte;
    bit         aborted;
    beats = 0; first_valid = -1; done_cycle = -1;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0; aborted = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = v.base; len = v.len; m_ready = v.ready[0];
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == v.mid_start) begin
        start = 1'b1; base_addr = 8'h55; len = 9'd2;
      end
      m_ready = v.ready[c % 16];
      if (c == 1) begin
        checkOutput({tag, "_busy1"}, 32'(busy), 32'(v.len != 0));
        if (v.len != 0) checkOutput({tag, "_addr1"}, 32'(mem_addr), 32'(v.base));
      end
      if (prev_stall) begin
        checkOutput({tag, "_hold_valid"}, 32'(m_valid), 32'd1);
        checkOutput({tag, "_hold_data"}, 32'(m_data), 32'(prev_data));
        checkOutput({tag, "_hold_last"}, 32'(m_last), 32'(prev_last));
      end
      if (m_valid && first_valid < 0) first_valid = c;
      if (m_valid && m_ready) begin
        exp_byte = (beats < 8) ? v.exp[8*beats +: 8] : 8'(int'(v.base) + beats);
        checkOutput($sformatf("%s_data%0d", tag, beats), 32'(m_data), 32'(exp_byte));
        checkOutput($sformatf("%s_last%0d", tag, beats), 32'(m_last),
                    32'(beats == int'(v.len) - 1));
        beats++;
        if (v.abort_beats != 0 && beats == v.abort_beats) begin
          rst_n = 1'b0;
          #1;
          checkOutput({tag, "_rst_valid"}, 32'(m_valid), 32'd0);
          checkOutput({tag, "_rst_data"}, 32'(m_data), 32'd0);
          checkOutput({tag, "_rst_last"}, 32'(m_last), 32'd0);
          checkOutput({tag, "_rst_addr"}, 32'(mem_addr), 32'd0);
          checkOutput({tag, "_rst_busy"}, 32'(busy), 32'd0);
          checkOutput({tag, "_rst_done"}, 32'(done), 32'd0);
          aborted = 1'b1;
          break;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) begin
        done_cycle = c;
        break;
      end
    end
    start = 1'b0;
    if (aborted) begin
      repeat (2) begin
        @(negedge clk);
        checkOutput({tag, "_rsthold_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_rsthold_valid"}, 32'(m_valid), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_post_done"}, 32'(done), 32'd0);
    end else begin
      checkOutput({tag, "_done_seen"}, 32'(done_cycle >= 0), 32'd1);
      checkOutput({tag, "_beats"}, 32'(beats), 32'(v.len));
      if (v.len != 0) checkOutput({tag, "_first_valid"}, 32'(first_valid), 32'd3);
      if (v.exp_done != 0) checkOutput({tag, "_done_cycle"}, 32'(done_cycle), 32'(v.exp_done));
      @(negedge clk);
      checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
      checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
      checkOutput({tag, "_valid_after"}, 32'(m_valid), 32'd0);
    end
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);

    //            base   len     ready     mid abort done exp beats (beat0 in low byte)
    vecs[0] = '{8'h10, 9'd4,   16'hFFFF, 0, 0, 7,   64'h0000_0000_1312_1110};
    vecs[1] = '{8'hFE, 9'd4,   16'hFFFF, 0, 0, 7,   64'h0000_0000_0100_FFFE};
    vecs[2] = '{8'h10, 9'd8,   16'h6969, 0, 0, 0,   64'h1716_1514_1312_1110};
    vecs[3] = '{8'h80, 9'd1,   16'hFFFF, 0, 0, 4,   64'h0000_0000_0000_0080};
    vecs[4] = '{8'h00, 9'd0,   16'hFFFF, 0, 0, 1,   64'h0000_0000_0000_0000};
    vecs[5] = '{8'h20, 9'd3,   16'hAAAA, 4, 0, 0,   64'h0000_0000_0022_2120};
    vecs[6] = '{8'h33, 9'd256, 16'hFFFF, 0, 0, 259, 64'h3A39_3837_3635_3433};
    abort_vec = '{8'h00, 9'd16, 16'hFFFF, 0, 5, 0, 64'h0706_0504_0302_0100};
    after_vec = '{8'h40, 9'd2,  16'hFFFF, 0, 0, 5, 64'h0000_0000_0000_4140};

    // Reset held with m_ready toggling: every output stays at zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_ready = ~m_ready;
      checkOutput("reset_valid", 32'(m_valid), 32'd0);
      checkOutput("reset_data", 32'(m_data), 32'd0);
      checkOutput("reset_last", 32'(m_last), 32'd0);
      checkOutput("reset_addr", 32'(mem_addr), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idle_valid", 32'(m_valid), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
    end
    m_ready = 1'b0;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset after five beats of a 16-word burst, then a clean short burst.
    applyStimulus(abort_vec, "abort");
    applyStimulus(after_vec, "after_abort");

    checkOutput("mem_we_never", 32'(we_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
